mem_1r1w_masked_bist: RTL and testbench

- Built-in self-test initiator that drives the R0/W0 ports of a lowered 1R1W masked memory (default 48x64, mask granularity 8).
- Writes an address-seeded pattern, reads it back, then does a masked partial overwrite and reads back the merged data.
- Sits beside the memory wrapper behind a test mux; functional logic owns the ports when the BIST is idle.
- Reports pass/fail, plus the first failing address and phase.

---
 rtl/mem_1r1w_masked_bist_if.sv | 26 ++
 rtl/mem_1r1w_masked_bist.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_1r1w_masked_bist.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_1r1w_masked_bist_if.sv
// R0/W0 port bundle of a lowered 1R1W masked memory.
// The BIST drives it as master; the memory wrapper sits on the slave side.
`timescale 1ns/1ps
interface mem_1r1w_masked_bist_if #(
    parameter int ADDR_W    = 6,
    parameter int WIDTH     = 64,
    parameter int MASK_GRAN = 8
);
    logic [ADDR_W-1:0]          W0_addr;
    logic                       W0_en;
    logic [WIDTH-1:0]           W0_data;
    logic [WIDTH/MASK_GRAN-1:0] W0_mask;
    logic [ADDR_W-1:0]          R0_addr;
    logic                       R0_en;
    logic [WIDTH-1:0]           R0_data;

    modport master (
        output W0_addr, W0_en, W0_data, W0_mask, R0_addr, R0_en,
        input  R0_data
    );

    modport slave (
        input  W0_addr, W0_en, W0_data, W0_mask, R0_addr, R0_en,
        output R0_data
    );
endinterface

// File: rtl/mem_1r1w_masked_bist.sv
// BIST initiator for a 1R1W masked memory: full pattern write/read, then masked overwrite/read.
// Optional MEM_BIST_ERR_COUNT_EN adds a saturating err_count and runs to completion on mismatch.
`timescale 1ns/1ps
module mem_1r1w_masked_bist #(
    parameter int DEPTH     = 48,
    parameter int WIDTH     = 64,
    parameter int MASK_GRAN = 8,
    parameter int ADDR_W    = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              fail_phase,
`ifdef MEM_BIST_ERR_COUNT_EN
    output logic [7:0]        err_count,
`endif
    mem_1r1w_masked_bist_if.master mem
);
    localparam int LANES = WIDTH / MASK_GRAN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE0 = 3'd1,
        ST_READ0  = 3'd2,
        ST_DRAIN0 = 3'd3,
        ST_WRITE1 = 3'd4,
        ST_READ1  = 3'd5,
        ST_DRAIN1 = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    // Lane k holds (address + 37*k), both taken modulo 2^MASK_GRAN.
    function automatic logic [WIDTH-1:0] pat_f(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0]     v;
        logic [MASK_GRAN-1:0] base;
        v    = '0;
        base = MASK_GRAN'(a);
        for (int k = 0; k < LANES; k++) begin
            v[k*MASK_GRAN +: MASK_GRAN] = base + MASK_GRAN'(32'd37 * k);
        end
        return v;
    endfunction

    function automatic logic [LANES-1:0] alt_mask_f();
        logic [LANES-1:0] m;
        m = '0;
        for (int k = 0; k < LANES; k++) begin
            m[k] = ((k % 2) == 0) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] expand_f(input logic [LANES-1:0] m);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            v[k*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{m[k]}};
        end
        return v;
    endfunction

    localparam logic [LANES-1:0] ALT_MASK = alt_mask_f();
    localparam logic [WIDTH-1:0] ALT_BITS = expand_f(ALT_MASK);

    state_t              state_r, state_nxt_s;
    logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
    logic                last_s, start_acc_s, mismatch_s, abort_s;
    logic                wr_nxt_s, rd_nxt_s;
    logic [WIDTH-1:0]    wdata_nxt_s, exp_s;
    logic [LANES-1:0]    wmask_nxt_s;
    logic                w0_en_r, r0_en_r, busy_r, done_r;
    logic [ADDR_W-1:0]   w0_addr_r, r0_addr_r;
    logic [WIDTH-1:0]    w0_data_r;
    logic [LANES-1:0]    w0_mask_r;
    logic                cmp_vld_r, cmp_phase_r;
    logic [ADDR_W-1:0]   cmp_addr_r;
    logic [WIDTH-1:0]    cmp_exp_r;
    logic                fail_r, fail_phase_r;
    logic [ADDR_W-1:0]   fail_addr_r;

    assign last_s      = (addr_r == LAST_ADDR);
    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign mismatch_s  = cmp_vld_r && (mem.R0_data != cmp_exp_r);
    // READ1 expects the inverted pattern only in lanes the masked overwrite touched.
    assign exp_s       = (state_r == ST_READ1) ? (pat_f(addr_r) ^ ALT_BITS) : pat_f(addr_r);
`ifdef MEM_BIST_ERR_COUNT_EN
    assign abort_s     = 1'b0;
`else
    assign abort_s     = mismatch_s;
`endif

    // Next-state and address-counter logic for the test sequence
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        if (abort_s) begin
            state_nxt_s = ST_DONE;
            addr_nxt_s  = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = start ? ST_WRITE0 : ST_IDLE;
                    addr_nxt_s  = '0;
                end
                ST_WRITE0, ST_READ0, ST_WRITE1, ST_READ1: begin
                    if (last_s) begin
                        state_nxt_s = state_t'(state_r + 3'd1);
                        addr_nxt_s  = '0;
                    end else begin
                        addr_nxt_s  = addr_r + ADDR_W'(1);
                    end
                end
                ST_DRAIN0: state_nxt_s = ST_WRITE1;
                ST_DRAIN1: state_nxt_s = ST_DONE;
                ST_DONE:   state_nxt_s = ST_IDLE;
                default: begin
                    state_nxt_s = ST_IDLE;
                    addr_nxt_s  = '0;
                end
            endcase
        end
    end

    // Memory-port values for the coming cycle, decoded from the next state
    always_comb begin
        wr_nxt_s    = (state_nxt_s == ST_WRITE0) || (state_nxt_s == ST_WRITE1);
        rd_nxt_s    = (state_nxt_s == ST_READ0) || (state_nxt_s == ST_READ1);
        wdata_nxt_s = '0;
        wmask_nxt_s = '0;
        case (state_nxt_s)
            ST_WRITE0: begin
                wdata_nxt_s = pat_f(addr_nxt_s);
                wmask_nxt_s = '1;
            end
            ST_WRITE1: begin
                wdata_nxt_s = ~pat_f(addr_nxt_s);
                wmask_nxt_s = ALT_MASK;
            end
            default: begin
                wdata_nxt_s = '0;
                wmask_nxt_s = '0;
            end
        endcase
    end

    // Sequencer state and address counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
        end
    end

    // Registered memory-port and status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w0_en_r   <= 1'b0;
            w0_addr_r <= '0;
            w0_data_r <= '0;
            w0_mask_r <= '0;
            r0_en_r   <= 1'b0;
            r0_addr_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            w0_en_r   <= wr_nxt_s;
            w0_addr_r <= wr_nxt_s ? addr_nxt_s : '0;
            w0_data_r <= wdata_nxt_s;
            w0_mask_r <= wmask_nxt_s;
            r0_en_r   <= rd_nxt_s;
            r0_addr_r <= rd_nxt_s ? addr_nxt_s : '0;
            busy_r    <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    // Tag each issued read so its data is checked one cycle later; a read issued while aborting is dropped
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmp_vld_r   <= 1'b0;
            cmp_addr_r  <= '0;
            cmp_exp_r   <= '0;
            cmp_phase_r <= 1'b0;
        end else begin
            cmp_vld_r   <= r0_en_r && !abort_s;
            cmp_addr_r  <= r0_addr_r;
            cmp_exp_r   <= exp_s;
            cmp_phase_r <= (state_r == ST_READ1);
        end
    end

    // Sticky failure flag with first-failure address and phase
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fail_r       <= 1'b0;
            fail_addr_r  <= '0;
            fail_phase_r <= 1'b0;
        end else if (start_acc_s) begin
            fail_r       <= 1'b0;
            fail_addr_r  <= '0;
            fail_phase_r <= 1'b0;
        end else if (mismatch_s && !fail_r) begin
            fail_r       <= 1'b1;
            fail_addr_r  <= cmp_addr_r;
            fail_phase_r <= cmp_phase_r;
        end
    end

`ifdef MEM_BIST_ERR_COUNT_EN
    logic [7:0] err_cnt_r;

    // Saturating mismatch counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_r <= 8'd0;
        end else if (start_acc_s) begin
            err_cnt_r <= 8'd0;
        end else if (mismatch_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign err_count = err_cnt_r;
`endif

    assign mem.W0_en   = w0_en_r;
    assign mem.W0_addr = w0_addr_r;
    assign mem.W0_data = w0_data_r;
    assign mem.W0_mask = w0_mask_r;
    assign mem.R0_en   = r0_en_r;
    assign mem.R0_addr = r0_addr_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign fail        = fail_r;
    assign fail_addr   = fail_addr_r;
    assign fail_phase  = fail_phase_r;
endmodule

// File: tb/tb_mem_1r1w_masked_bist.sv
// Scoreboard bench for mem_1r1w_masked_bist against a behavioural masked memory with injectable faults.
`timescale 1ns/1ps
module tb_mem_1r1w_masked_bist;
    localparam int DEPTH = 48, WIDTH = 64, MASK_GRAN = 8, ADDR_W = 6;
    localparam logic [63:0] P2  = 64'h05E0_BB96_714C_2702;
    localparam logic [63:0] NP2 = 64'hFA1F_4469_8EB3_D8FD;
`ifdef MEM_BIST_ERR_COUNT_EN
    localparam bit ERRC = 1'b1;
`else
    localparam bit ERRC = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic start = 1'b0;
    logic busy, done, fail, fail_phase;
    logic [ADDR_W-1:0] fail_addr;
`ifdef MEM_BIST_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    mem_1r1w_masked_bist_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .MASK_GRAN(MASK_GRAN)) mif();

    mem_1r1w_masked_bist #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(MASK_GRAN), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_phase (fail_phase),
`ifdef MEM_BIST_ERR_COUNT_EN
        .err_count  (err_count),
`endif
        .mem        (mif)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural memory: fault 1 ignores the lane mask, fault 2 reads bit 5 of word 47 as 0
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q = '0;
    int fault = 0;
    assign mif.R0_data = rdata_q;

    always @(posedge clock) begin
        if (mif.W0_en && (int'(mif.W0_addr) < DEPTH)) begin
            for (int k = 0; k < WIDTH / MASK_GRAN; k++) begin
                if (fault == 1 || mif.W0_mask[k]) begin
                    mem_q[mif.W0_addr][k*MASK_GRAN +: MASK_GRAN] <= mif.W0_data[k*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
        if (mif.R0_en) begin
            rdata_q <= mem_q[mif.R0_addr];
            if (fault == 2 && mif.R0_addr == 6'd47) rdata_q[5] <= 1'b0;
        end
    end

    typedef struct {
        int unsigned done_cyc;
        logic        fail;
        logic [5:0]  addr;
        logic        phase;
        int          busy_n;
        int          wr_n;
        int          rd_n;
        int          errs;
    } exp_t;

    exp_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: protocol checks every cycle, scoreboard pop on each done pulse
    int busy_n = 0, wr_n = 0, rd_n = 0, max_addr = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                busy_n = 0; wr_n = 0; rd_n = 0; max_addr = 0;
            end else begin
                chk("enables_exclusive", {63'd0, mif.W0_en & mif.R0_en}, 64'd0);
                if (busy) busy_n++;
                if (mif.W0_en) begin
                    chk("w0_mask", {56'd0, mif.W0_mask}, (wr_n < DEPTH) ? 64'hFF : 64'h55);
                    if (mif.W0_addr == 6'd2) chk("w0_data_addr2", mif.W0_data, (wr_n < DEPTH) ? P2 : NP2);
                    if (int'(mif.W0_addr) > max_addr) max_addr = int'(mif.W0_addr);
                    wr_n++;
                end
                if (mif.R0_en) begin
                    if (int'(mif.R0_addr) > max_addr) max_addr = int'(mif.R0_addr);
                    rd_n++;
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                        chk("busy_at_done", {63'd0, busy}, 64'd0);
                        chk("fail", {63'd0, fail}, {63'd0, e.fail});
                        chk("fail_addr", {58'd0, fail_addr}, {58'd0, e.addr});
                        chk("fail_phase", {63'd0, fail_phase}, {63'd0, e.phase});
                        chk("busy_cycles", 64'(busy_n), 64'(e.busy_n));
                        chk("write_cycles", 64'(wr_n), 64'(e.wr_n));
                        chk("read_cycles", 64'(rd_n), 64'(e.rd_n));
                        chk("max_addr", 64'(max_addr), 64'd47);
`ifdef MEM_BIST_ERR_COUNT_EN
                        chk("err_count", {56'd0, err_count}, 64'(e.errs));
`endif
                    end
                    busy_n = 0; wr_n = 0; rd_n = 0; max_addr = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_start(output int unsigned t0);
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick();
    endtask

    task automatic wait_sb();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done within 400 cycles, expected %0d pending", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_fail"}, {63'd0, fail}, 64'd0);
        chk({tag, "_fail_addr"}, {58'd0, fail_addr}, 64'd0);
        chk({tag, "_w0_en"}, {63'd0, mif.W0_en}, 64'd0);
        chk({tag, "_r0_en"}, {63'd0, mif.R0_en}, 64'd0);
        chk({tag, "_w0_addr"}, {58'd0, mif.W0_addr}, 64'd0);
        chk({tag, "_r0_addr"}, {58'd0, mif.R0_addr}, 64'd0);
        chk({tag, "_w0_data"}, mif.W0_data, 64'd0);
    endtask

    initial begin
        int unsigned t0;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Ideal memory; extra start pulses mid-test and in the DONE cycle must be ignored
        fault = 0;
        run_start(t0);
        sb_q.push_back('{t0 + 195, 1'b0, 6'd0, 1'b0, 194, 96, 96, 0});
        wait_until(t0 + 10);
        start = 1'b1; tick(); start = 1'b0;
        wait_until(t0 + 195);
        start = 1'b1; tick(); start = 1'b0;
        wait_sb();
        repeat (5) tick();
        chk("idle_after_ignored_start", {63'd0, busy}, 64'd0);

        // Memory ignores the lane mask: first READ1 compare fails at address 0
        fault = 1;
        run_start(t0);
        if (ERRC) sb_q.push_back('{t0 + 195, 1'b1, 6'd0, 1'b1, 194, 96, 96, 48});
        else      sb_q.push_back('{t0 + 148, 1'b1, 6'd0, 1'b1, 147, 96, 50, 0});
        wait_sb();
        repeat (3) tick();

        // Bit 5 of word 47 stuck at 0: fails on the last READ0 compare in DRAIN0
        fault = 2;
        run_start(t0);
        if (ERRC) sb_q.push_back('{t0 + 195, 1'b1, 6'd47, 1'b0, 194, 96, 96, 1});
        else      sb_q.push_back('{t0 + 98, 1'b1, 6'd47, 1'b0, 97, 48, 48, 0});
        wait_sb();
        repeat (3) tick();

        // New start clears the previous failure; reset mid-test forces everything low at once
        fault = 0;
        run_start(t0);
        chk("fail_cleared_on_start", {63'd0, fail}, 64'd0);
        chk("fail_addr_cleared_on_start", {58'd0, fail_addr}, 64'd0);
        wait_until(t0 + 60);
        #1 reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Clean run after the aborted one
        run_start(t0);
        sb_q.push_back('{t0 + 195, 1'b0, 6'd0, 1'b0, 194, 96, 96, 0});
        wait_sb();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
